// File: rtl/bsg_flow_credit_arb.sv
// Round-robin arbiter for channels sharing one credit-controlled link.
// Per-channel credit counters are restored by token pulses.
module bsg_flow_credit_arb #(
  parameter int channels_p = 4,
  parameter int credits_p = 8,
  parameter int decimation_p = 1,
  localparam int lg_chan_lp =
    (channels_p > 1) ? $clog2(channels_p) : 1,
  localparam int cnt_w_lp = $clog2(credits_p + 1)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic [channels_p-1:0] v_i,
  output logic [channels_p-1:0] yumi_o,
  output logic v_o,
  output logic [lg_chan_lp-1:0] chan_o,
  input  logic ready_i,
  input  logic [channels_p-1:0] token_i,
  output logic [channels_p*cnt_w_lp-1:0] credit_cnt_o,
  output logic overflow_o
);

  localparam int sum_w_lp = cnt_w_lp + 1;

  logic [cnt_w_lp-1:0] cnt_r [channels_p];
  logic [cnt_w_lp-1:0] cnt_n [channels_p];
  logic [sum_w_lp-1:0] sum [channels_p];
  logic [lg_chan_lp-1:0] last_r;
  logic overflow_r;
  logic [channels_p-1:0] elig;
  logic [channels_p-1:0] ovf_c;
  logic [channels_p-1:0] yumi;
  logic [lg_chan_lp-1:0] chan;

  always_comb begin
    for (int c = 0; c < channels_p; c++) begin
      elig[c] = v_i[c] && (cnt_r[c] != '0);
    end
  end

  // Search begins one past the last winner.
  always_comb begin
    int idx;
    logic found;
    logic [lg_chan_lp-1:0] sel;
    yumi = '0;
    chan = '0;
    found = 1'b0;
    idx = 0;
    sel = '0;
    for (int k = 1; k <= channels_p; k++) begin
      idx = (int'(last_r) + k) % channels_p;
      sel = lg_chan_lp'(idx);
      if (!found && elig[sel]) begin
        found = 1'b1;
        yumi[sel] = 1'b1;
        chan = sel;
      end
    end
    if (!ready_i || reset_i) begin
      yumi = '0;
      chan = '0;
    end
  end

  always_comb begin
    for (int c = 0; c < channels_p; c++) begin
      sum[c] = {1'b0, cnt_r[c]}
        + (token_i[c] ? sum_w_lp'(decimation_p) : '0)
        - (yumi[c] ? sum_w_lp'(1) : '0);
      ovf_c[c] = 1'b0;
      cnt_n[c] = sum[c][cnt_w_lp-1:0];
      if (sum[c] > sum_w_lp'(credits_p)) begin
        ovf_c[c] = 1'b1;
        cnt_n[c] = cnt_w_lp'(credits_p);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int c = 0; c < channels_p; c++) begin
        cnt_r[c] <= cnt_w_lp'(credits_p);
      end
      last_r <= lg_chan_lp'(channels_p - 1);
      overflow_r <= 1'b0;
    end else begin
      for (int c = 0; c < channels_p; c++) begin
        cnt_r[c] <= cnt_n[c];
      end
      if (|yumi) last_r <= chan;
      if (|ovf_c) overflow_r <= 1'b1;
    end
  end

  always_comb begin
    for (int c = 0; c < channels_p; c++) begin
      credit_cnt_o[c*cnt_w_lp +: cnt_w_lp] = cnt_r[c];
    end
  end

  assign yumi_o = yumi;
  assign v_o = |yumi;
  assign chan_o = chan;
  assign overflow_o = overflow_r;

endmodule

// File: tb/tb_bsg_flow_credit_arb.sv
// Bench for bsg_flow_credit_arb: directed scenarios plus random
// traffic against a credit-pool reference model.
module tb_bsg_flow_credit_arb;

  localparam int N = 4;
  localparam int CR = 8;

  logic clk;
  logic reset_i;
  logic [3:0] v_i, yumi_o, token_i;
  logic v_o, ready_i, overflow_o;
  logic [1:0] chan_o;
  logic [15:0] credit_cnt_o;

  logic [3:0] v4, yumi4, tok4;
  logic vo4, ovf4;
  logic [1:0] chan4;
  logic [15:0] cnt4;

  int checks = 0;
  int errors = 0;
  int cred [N];
  int last;
  bit ovf;

  bsg_flow_credit_arb dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i),
    .yumi_o(yumi_o), .v_o(v_o), .chan_o(chan_o),
    .ready_i(ready_i), .token_i(token_i),
    .credit_cnt_o(credit_cnt_o),
    .overflow_o(overflow_o)
  );

  bsg_flow_credit_arb #(.decimation_p(4)) dut4 (
    .clk_i(clk), .reset_i(reset_i), .v_i(v4),
    .yumi_o(yumi4), .v_o(vo4), .chan_o(chan4),
    .ready_i(ready_i), .token_i(tok4),
    .credit_cnt_o(cnt4),
    .overflow_o(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] packed_cred();
    logic [15:0] p;
    for (int c = 0; c < N; c++) p[c*4 +: 4] = 4'(cred[c]);
    return p;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) cred[c] = CR;
    last = N - 1;
    ovf = 0;
  endtask

  // Called at posedge+1; checks at negedge; returns at posedge+1.
  task automatic step(input logic [3:0] v, input logic r,
                      input logic [3:0] t, input int want);
    int g;
    int n;
    logic [3:0] ey;
    v_i = v;
    ready_i = r;
    token_i = t;
    #4;
    g = -1;
    if (r) begin
      for (int k = 1; k <= N; k++) begin
        n = (last + k) % N;
        if (g < 0 && v[n] && cred[n] > 0) g = n;
      end
    end
    ey = 4'b0;
    if (g >= 0) ey[g] = 1'b1;
    check("yumi", 32'(yumi_o), 32'(ey));
    check("v_o", 32'(v_o), 32'(g >= 0));
    check("chan", 32'(chan_o), (g >= 0) ? 32'(g) : 0);
    check("cnt", 32'(credit_cnt_o), 32'(packed_cred()));
    check("ovf", 32'(overflow_o), 32'(ovf));
    if (want != -2) check("rr_order", 32'(chan_o), 32'(want));
    @(posedge clk);
    for (int c = 0; c < N; c++) begin
      n = cred[c] + (t[c] ? 1 : 0) - ((g == c) ? 1 : 0);
      if (n > CR) begin
        n = CR;
        ovf = 1;
      end
      cred[c] = n;
    end
    if (g >= 0) last = g;
    #1;
  endtask

  initial begin
    reset_i = 1'b1;
    v_i = 4'hf;
    ready_i = 1'b1;
    token_i = 4'hf;
    v4 = 4'h0;
    tok4 = 4'h0;
    model_reset();
    #10;
    check("rst_yumi", 32'(yumi_o), 0);
    check("rst_v_o", 32'(v_o), 0);
    check("rst_chan", 32'(chan_o), 0);
    check("rst_cnt", 32'(credit_cnt_o), 32'h8888);
    check("rst_ovf", 32'(overflow_o), 0);
    check("rst_cnt4", 32'(cnt4), 32'h8888);
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    token_i = 4'h0;

    // Full round-robin drain; dut4 checks grant+token merge.
    for (int i = 0; i < 32; i++) begin
      v4 = (i < 7) ? 4'b0001 : 4'b0000;
      tok4 = (i == 6) ? 4'b0001 : 4'b0000;
      step(4'hf, 1'b1, 4'h0, i % 4);
      if (i == 5) check("dec_pre", 32'(cnt4[3:0]), 2);
      if (i == 6) check("dec_merge", 32'(cnt4[3:0]), 5);
    end
    check("drained", 32'(credit_cnt_o), 0);
    step(4'hf, 1'b1, 4'h0, -2);
    check("no_grant_empty", 32'(v_o), 0);
    step(4'hf, 1'b1, 4'h0, -2);

    // Token on starved channel: eligible the following cycle.
    step(4'b0010, 1'b1, 4'b0010, -2);
    check("ch1_cnt1", 32'(credit_cnt_o[7:4]), 1);
    step(4'b0010, 1'b1, 4'b0000, 1);

    // Fill ch3 then over-return.
    for (int i = 0; i < 8; i++) step(4'h0, 1'b1, 4'b1000, -2);
    check("ch3_full", 32'(credit_cnt_o[15:12]), 8);
    step(4'h0, 1'b1, 4'b1000, -2);
    check("ch3_sat", 32'(credit_cnt_o[15:12]), 8);
    check("ovf_set", 32'(overflow_o), 1);
    for (int i = 0; i < 4; i++) step(4'b0010, 1'b1, 4'b0010, -2);
    check("ovf_sticky", 32'(overflow_o), 1);

    // Asynchronous reset between edges.
    v_i = 4'hf;
    ready_i = 1'b1;
    #2;
    check("pre_rst_v_o", 32'(v_o), 1);
    reset_i = 1'b1;
    #1;
    check("arst_yumi", 32'(yumi_o), 0);
    check("arst_v_o", 32'(v_o), 0);
    check("arst_chan", 32'(chan_o), 0);
    check("arst_cnt", 32'(credit_cnt_o), 32'h8888);
    check("arst_ovf", 32'(overflow_o), 0);
    token_i = 4'hf;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("hold_cnt", 32'(credit_cnt_o), 32'h8888);
    check("hold_yumi", 32'(yumi_o), 0);
    reset_i = 1'b0;
    token_i = 4'h0;
    model_reset();
    step(4'hf, 1'b1, 4'h0, 0);

    // Ready toggling, two requesters.
    for (int i = 0; i < 16; i++) begin
      step(4'b0101, 1'(i % 2 == 0), 4'h0, -2);
    end

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] rv, rt;
      logic rr;
      rv = 4'($urandom);
      rr = ($urandom_range(0, 3) != 0);
      rt = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      step(rv, rr, rt, -2);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
